// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings for the divide
// group and the divider FSM state type.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a
// register-file style write-back (regWrite/rd/wd) and a start/busy/done handshake.
module div_unit
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            regWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd,
  output div_state_t      dbg_state
);

  // Handshake: start is sampled only while the FSM is IDLE (operands too);
  // busy rises on the accepting edge and stays high through the one-cycle
  // done pulse; a new start may be accepted on the edge that ends that pulse.

  div_state_t      state;
  logic [5:0]      count;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic [4:0]      rd_q;
  logic            sel_rem;
  logic            neg_q;
  logic            neg_r;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;

  always_comb begin
    op_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
    op_rem    = (funct3 == F3_REM) || (funct3 == F3_REMU);
    a_neg     = op_signed && rs1_val[XLEN-1];
    b_neg     = op_signed && rs2_val[XLEN-1];
    // Negating 0x8000_0000 wraps back to itself, which is its unsigned magnitude.
    a_mag     = a_neg ? -rs1_val : rs1_val;
    b_mag     = b_neg ? -rs2_val : rs2_val;
    div_zero  = (rs2_val == '0);
    overflow  = op_signed && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
  end

  // One restoring step: the partial remainder never exceeds the divisor, so
  // after the shift it fits in XLEN+1 bits and the difference fits in XLEN.
  logic [XLEN:0]   shift_rem;
  logic [XLEN-1:0] diff;
  logic            fits;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  always_comb begin
    shift_rem = {rem, quo[XLEN-1]};
    fits      = (shift_rem >= {1'b0, dvsr});
    diff      = shift_rem[XLEN-1:0] - dvsr;
    step_rem  = fits ? diff : shift_rem[XLEN-1:0];
    step_quo  = {quo[XLEN-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      rd_q     <= '0;
      sel_rem  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      regWrite <= 1'b0;
      rd       <= '0;
      wd       <= '0;
    end else begin
      done     <= 1'b0;
      regWrite <= 1'b0;
      case (state)
        IDLE: begin
          // Clears busy at the end of the done pulse unless a new op starts.
          busy <= start;
          if (start) begin
            rd_q    <= rd_in;
            sel_rem <= op_rem;
            count   <= '0;
            if (div_zero) begin
              quo   <= '1;
              rem   <= rs1_val;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else if (overflow) begin
              quo   <= 32'h8000_0000;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              dvsr  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= step_rem;
          quo   <= step_quo;
          count <= count + 6'd1;
          if (count == 6'd31) state <= FIX;
        end
        FIX: begin
          if (neg_q) quo <= -quo;
          if (neg_r) rem <= -rem;
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b1;
          regWrite <= (rd_q != 5'd0);
          rd       <= rd_q;
          wd       <= sel_rem ? rem : quo;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected write-backs,
// a small register-file model and per-feature scenario tasks.
module tb_div_unit;
  import rv32m_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] wd;
  div_state_t  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q[$];
  logic [31:0] rf [32];

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .regWrite(regWrite), .rd(rd), .wd(wd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  // Register-file model: writes on any strobe, so a strobe with rd=0 corrupts x0.
  always @(posedge clk) if (regWrite) rf[rd] <= wd;

  // Reference results from native SV arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F3_DIV:  ref_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                                  : 32'($signed(a) / $signed(b));
      F3_REM:  ref_res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      F3_REMU: ref_res = (b == 0) ? a : a % b;
      default: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: rd=%0d wd=%h with empty queue", rd, wd);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        if ({regWrite, rd, wd} !== e) begin
          bad++;
          $display("FAIL writeback: got rw=%b rd=%0d wd=%h want rw=%b rd=%0d wd=%h",
                   regWrite, rd, wd, e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = r; start = 1'b1;
    exp_q.push_back({r != 5'd0, r, ref_res(f, a, b)});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom;
    rd_in = 5'($urandom_range(0, 31)); funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy, done, regWrite, rd, wd} !== 39'd0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b rw=%b rd=%0d wd=%h state=%0d want all 0/IDLE",
               busy, done, regWrite, rd, wd, dbg_state);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b state=%0d want 0/IDLE", busy, dbg_state);
    end
  endtask

  task automatic test_unsigned;
    int c;
    issue(F3_DIVU, 32'd100, 32'd7, 5'd5);
    wait_done(c);
    total++;
    if (c !== 34 || wd !== 32'd14 || regWrite !== 1'b1 || rd !== 5'd5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL divu_100_7: lat=%0d wd=%0d rw=%b rd=%0d busy=%b want 34/14/1/5/1",
               c, wd, regWrite, rd, busy);
    end
    @(negedge clk);
    issue(F3_REMU, 32'd100, 32'd7, 5'd5);
    wait_done(c);
    total++;
    if (c !== 34 || wd !== 32'd2) begin
      bad++;
      $display("FAIL remu_100_7: lat=%0d wd=%0d want 34/2", c, wd);
    end
    @(negedge clk);
  endtask

  task automatic test_signed;
    int c;
    logic [2:0]  f [3] = '{F3_DIV, F3_REM, F3_DIV};
    logic [31:0] a [3] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20};
    logic [31:0] b [3] = '{32'd3, 32'd3, 32'hFFFF_FFFD};
    logic [31:0] w [3] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFA};
    for (int i = 0; i < 3; i++) begin
      issue(f[i], a[i], b[i], 5'd9);
      wait_done(c);
      total++;
      if (c !== 34 || wd !== w[i]) begin
        bad++;
        $display("FAIL signed_%0d: lat=%0d wd=%h want 34/%h", i, c, wd, w[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int c;
    issue(F3_DIV, 32'd42, 32'd0, 5'd3);
    wait_done(c);
    total++;
    if (c !== 1 || wd !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_by_zero: lat=%0d wd=%h want 1/ffffffff", c, wd);
    end
    @(negedge clk);
    issue(F3_REMU, 32'd42, 32'd0, 5'd3);
    wait_done(c);
    total++;
    if (c !== 1 || wd !== 32'd42) begin
      bad++;
      $display("FAIL remu_by_zero: lat=%0d wd=%0d want 1/42", c, wd);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int c;
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_done(c);
    total++;
    if (c !== 1 || wd !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_overflow: lat=%0d wd=%h want 1/80000000", c, wd);
    end
    @(negedge clk);
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_done(c);
    total++;
    if (c !== 1 || wd !== 32'd0) begin
      bad++;
      $display("FAIL rem_overflow: lat=%0d wd=%h want 1/0", c, wd);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int c;
    issue(F3_DIVU, 32'd100, 32'd7, 5'd6);
    repeat (5) @(negedge clk);
    funct3 = F3_DIV; rs1_val = 32'd999; rs2_val = 32'd2; rd_in = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    total++;
    if (c < 0 || wd !== 32'd14 || rd !== 5'd6) begin
      bad++;
      $display("FAIL busy_ignore: lat=%0d wd=%0d rd=%0d want 14/6", c, wd, rd);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_idle: queue=%0d busy=%b want 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_abort;
    int c;
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || regWrite !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_abort: busy=%b done=%b rw=%b state=%0d want 0/0/0/IDLE",
               busy, done, regWrite, dbg_state);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (rf[7] !== 32'd0) begin
      bad++;
      $display("FAIL abort_no_write: x7=%h want 0", rf[7]);
    end
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd7);
    wait_done(c);
    @(negedge clk);
    total++;
    if (c !== 34 || rf[7] !== 32'd333) begin
      bad++;
      $display("FAIL restart_after_reset: lat=%0d x7=%0d want 34/333", c, rf[7]);
    end
  endtask

  task automatic test_regfile;
    int c;
    issue(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    wait_done(c);
    total++;
    if (c !== 34 || done !== 1'b1 || regWrite !== 1'b0) begin
      bad++;
      $display("FAIL rd0_no_write: lat=%0d done=%b rw=%b want 34/1/0", c, done, regWrite);
    end
    @(negedge clk);
    total++;
    if (rf[0] !== 32'd0) begin
      bad++;
      $display("FAIL x0_zero: x0=%h want 0", rf[0]);
    end
    issue(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd10);
    wait_done(c);
    @(negedge clk);
    total++;
    if (rf[10] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL x10_write: x10=%h want ffffffff", rf[10]);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(F3_REMU, 32'd12345, 32'd100, 5'd11);
    wait_done(c);
    issue(F3_DIVU, 32'd12345, 32'd100, 5'd12);
    total++;
    if (busy !== 1'b1 || dbg_state !== CALC) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b state=%0d want 1/CALC", busy, dbg_state);
    end
    wait_done(c);
    total++;
    if (c !== 34 || wd !== 32'd123) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d wd=%0d want 34/123", c, wd);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int c;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      b = (i == 3) ? 32'd0 : $urandom;
      if (i[0]) b = b >> $urandom_range(0, 31);
      issue(3'($urandom_range(4, 7)), $urandom, b, 5'($urandom_range(0, 31)));
      wait_done(c);
      total++;
      if (c < 0) begin
        bad++;
        $display("FAIL random_timeout: op %0d never completed", i);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_busy_ignore;
    test_reset_abort;
    test_regfile;
    test_back_to_back;
    test_random;
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL leftover_expected: %0d results never produced, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
